// File: rtl/alu_pkg.sv
// Shared constants and types for the EX-stage operand path.
//   DATA_W / SHAMT_W / JUMP_W : default datapath widths
//   J_JAL / J_JALR / J_BAL    : jump-type codes that form a link address
//   JUMP_PC_MASK_DEF          : bit k set -> jump code k selects A=PC, B=link offset
//   LINK_OFFSET_DEF           : constant B operand for link-address jumps
//   skid_state_e              : occupancy of the 2-entry skid register
package alu_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned SHAMT_W = 5;
  localparam int unsigned JUMP_W  = 3;

  localparam logic [JUMP_W-1:0] J_JALR = 3'b100;
  localparam logic [JUMP_W-1:0] J_JAL  = 3'b101;
  localparam logic [JUMP_W-1:0] J_BAL  = 3'b111;

  localparam logic [(2**JUMP_W)-1:0] JUMP_PC_MASK_DEF = 8'hB0;
  localparam int unsigned            LINK_OFFSET_DEF  = 8;

  // Encoding mirrors {skid_valid, main_valid}.
  typedef enum logic [1:0] {
    StEmpty = 2'b00,
    StOne   = 2'b01,
    StFull  = 2'b11
  } skid_state_e;

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic 2-entry valid/ready skid register.
//   clk_i, rst_i    : clock, synchronous active-high reset
//   flush_i         : synchronous kill of both entries (input in same cycle dropped)
//   valid_i/ready_o : upstream handshake; ready_o depends only on registered state
//   data_i          : payload captured on acceptance
//   valid_o/ready_i : downstream handshake
//   data_o          : payload of the main (oldest) entry, stable while stalled
module pipe_skid_buf
  import alu_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         flush_i,
  input  logic         valid_i,
  output logic         ready_o,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  input  logic         ready_i,
  output logic [W-1:0] data_o
);

  skid_state_e state_q, state_d;
  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q, skid_d;
  logic         acc, pop;

  assign ready_o = (state_q != StFull);
  assign valid_o = (state_q != StEmpty);
  assign data_o  = main_q;

  assign acc = valid_i & ready_o;
  assign pop = valid_o & ready_i;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      StEmpty: begin
        if (acc) begin
          main_d  = data_i;
          state_d = StOne;
        end
      end
      StOne: begin
        if (acc && pop) begin
          main_d = data_i;
        end else if (acc) begin
          skid_d  = data_i;
          state_d = StFull;
        end else if (pop) begin
          state_d = StEmpty;
        end
      end
      StFull: begin
        // No acceptance possible here; only drain the skid into main.
        if (pop) begin
          main_d  = skid_q;
          state_d = StOne;
        end
      end
      default: state_d = StEmpty;
    endcase
    // Data registers may keep stale contents; only occupancy is killed.
    if (flush_i) begin
      state_d = StEmpty;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StEmpty;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: rtl/alu_operand_stage.sv
// EX-stage operand unit: selects ALU operands A/B (including link-address
// formation for JAL/JALR/BAL) and registers them with a tag behind a
// 2-entry skid buffer so a stalling ALU/MDU never loses an instruction.
//   clk_i, rst_i, flush_i         : clock, sync active-high reset, sync flush
//   in_valid_i / in_ready_o       : upstream handshake
//   fwd_a_i, fwd_b_i              : forwarded rs / rt data
//   shamt_i, imm_i, pc_i          : shift amount, extended immediate, PC
//   jump_sig_i                    : jump-type code
//   src_a_shamt_i, src_b_imm_i    : A/B source selects
//   in_tag_i / out_tag_o          : sideband carried with the operands
//   out_valid_o / out_ready_i     : downstream handshake
//   op_a_o, op_b_o                : registered operands
module alu_operand_stage #(
  parameter int unsigned                  DATA_W       = alu_pkg::DATA_W,
  parameter int unsigned                  SHAMT_W      = alu_pkg::SHAMT_W,
  parameter int unsigned                  JUMP_W       = alu_pkg::JUMP_W,
  parameter logic [(2**JUMP_W)-1:0]       JUMP_PC_MASK = alu_pkg::JUMP_PC_MASK_DEF,
  parameter int unsigned                  LINK_OFFSET  = alu_pkg::LINK_OFFSET_DEF,
  parameter int unsigned                  TAG_W        = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] fwd_a_i,
  input  logic [DATA_W-1:0] fwd_b_i,
  input  logic [SHAMT_W-1:0] shamt_i,
  input  logic [DATA_W-1:0] imm_i,
  input  logic [DATA_W-1:0] pc_i,
  input  logic [JUMP_W-1:0] jump_sig_i,
  input  logic              src_a_shamt_i,
  input  logic              src_b_imm_i,
  input  logic [TAG_W-1:0]  in_tag_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] op_a_o,
  output logic [DATA_W-1:0] op_b_o,
  output logic [TAG_W-1:0]  out_tag_o
);

  localparam int unsigned W = 2 * DATA_W + TAG_W;

  logic              link_sel;
  logic [DATA_W-1:0] sel_a, sel_b;
  logic [W-1:0]      buf_in, buf_out;

  // Link-address jumps override both source selects.
  assign link_sel = JUMP_PC_MASK[jump_sig_i];

  always_comb begin
    sel_a = fwd_a_i;
    sel_b = fwd_b_i;
    if (link_sel) begin
      sel_a = pc_i;
      sel_b = DATA_W'(LINK_OFFSET);
    end else begin
      if (src_a_shamt_i) sel_a = {{(DATA_W - SHAMT_W){1'b0}}, shamt_i};
      if (src_b_imm_i)   sel_b = imm_i;
    end
  end

  assign buf_in = {sel_a, sel_b, in_tag_i};

  pipe_skid_buf #(
    .W(W)
  ) u_skid (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (flush_i),
    .valid_i (in_valid_i),
    .ready_o (in_ready_o),
    .data_i  (buf_in),
    .valid_o (out_valid_o),
    .ready_i (out_ready_i),
    .data_o  (buf_out)
  );

  assign op_a_o    = buf_out[W-1 -: DATA_W];
  assign op_b_o    = buf_out[TAG_W +: DATA_W];
  assign out_tag_o = buf_out[TAG_W-1:0];

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage: operand selection, link jumps,
// backpressure ordering, flush and reset behaviour.
module tb_alu_operand_stage;

  logic        clk;
  logic        rst, flush, in_valid, in_ready;
  logic [31:0] fwd_a, fwd_b, imm, pc;
  logic [4:0]  shamt;
  logic [2:0]  jump_sig;
  logic        src_a_shamt, src_b_imm;
  logic [7:0]  in_tag, out_tag;
  logic        out_valid, out_ready;
  logic [31:0] op_a, op_b;

  int n_chk = 0;
  int n_bad = 0;

  alu_operand_stage dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .flush_i       (flush),
    .in_valid_i    (in_valid),
    .in_ready_o    (in_ready),
    .fwd_a_i       (fwd_a),
    .fwd_b_i       (fwd_b),
    .shamt_i       (shamt),
    .imm_i         (imm),
    .pc_i          (pc),
    .jump_sig_i    (jump_sig),
    .src_a_shamt_i (src_a_shamt),
    .src_b_imm_i   (src_b_imm),
    .in_tag_i      (in_tag),
    .out_valid_o   (out_valid),
    .out_ready_i   (out_ready),
    .op_a_o        (op_a),
    .op_b_o        (op_b),
    .out_tag_o     (out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [2:0] jcodes [3];

  initial begin
    jcodes[0] = 3'b101;
    jcodes[1] = 3'b100;
    jcodes[2] = 3'b111;

    rst = 1; flush = 0; in_valid = 0; out_ready = 0;
    fwd_a = 0; fwd_b = 0; imm = 0; pc = 0; shamt = 0; jump_sig = 0;
    src_a_shamt = 0; src_b_imm = 0; in_tag = 0;
    step(); step();
    rst = 0;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_op_a", op_a, 32'd0);
    check("rst_op_b", op_b, 32'd0);
    check("rst_tag", 32'(out_tag), 32'd0);

    // R-type ADD
    fwd_a = 32'h11; fwd_b = 32'h22; in_tag = 8'hA1; in_valid = 1; out_ready = 1;
    step();
    check("add_valid", 32'(out_valid), 32'd1);
    check("add_op_a", op_a, 32'h11);
    check("add_op_b", op_b, 32'h22);
    check("add_tag", 32'(out_tag), 32'hA1);

    // SLL: A = zero-extended shamt
    src_a_shamt = 1; shamt = 5'd31; fwd_a = 32'hFFFF_FFFF; fwd_b = 32'h5; in_tag = 8'hA2;
    step();
    check("sll_op_a", op_a, 32'h0000_001F);
    check("sll_op_b", op_b, 32'h5);

    // Link-address jumps override both selects
    pc = 32'h0040_0010; src_b_imm = 1; imm = 32'h1234;
    for (int i = 0; i < 3; i++) begin
      jump_sig = jcodes[i];
      step();
      check("jmp_op_a", op_a, 32'h0040_0010);
      check("jmp_op_b", op_b, 32'd8);
    end
    jump_sig = 3'b110;
    step();
    check("j110_op_a", op_a, 32'h0000_001F);
    check("j110_op_b", op_b, 32'h1234);

    jump_sig = 0; src_a_shamt = 0; src_b_imm = 0;
    in_valid = 0;
    step();
    check("drain_valid", 32'(out_valid), 32'd0);

    // Backpressure: tags 1,2,3 back to back
    out_ready = 0; in_valid = 1; in_tag = 8'd1;
    step();
    check("bp1_valid", 32'(out_valid), 32'd1);
    check("bp1_tag", 32'(out_tag), 32'd1);
    check("bp1_ready", 32'(in_ready), 32'd1);
    in_tag = 8'd2;
    step();
    check("bp2_ready", 32'(in_ready), 32'd0);
    check("bp2_tag", 32'(out_tag), 32'd1);
    in_tag = 8'd3;
    step();
    check("bp3_ready", 32'(in_ready), 32'd0);
    check("bp3_tag", 32'(out_tag), 32'd1);
    out_ready = 1;   // tag 1 consumed at next edge
    step();
    check("bp_out2_tag", 32'(out_tag), 32'd2);
    check("bp_out2_valid", 32'(out_valid), 32'd1);
    check("bp_out2_ready", 32'(in_ready), 32'd1);
    step();          // tag 3 accepted while tag 2 pops
    check("bp_out3_tag", 32'(out_tag), 32'd3);
    check("bp_out3_valid", 32'(out_valid), 32'd1);
    in_valid = 0;
    step();
    check("bp_empty", 32'(out_valid), 32'd0);

    // Flush while FULL
    out_ready = 0; in_valid = 1; in_tag = 8'd4;
    step();
    in_tag = 8'd5;
    step();
    check("fl_full_ready", 32'(in_ready), 32'd0);
    flush = 1; in_tag = 8'd6;
    step();
    check("fl_full_valid", 32'(out_valid), 32'd0);
    check("fl_full_ready2", 32'(in_ready), 32'd1);
    flush = 0; in_valid = 0;
    step();
    check("fl_full_drop", 32'(out_valid), 32'd0);

    // Flush while ONE with an input presented: input dropped
    in_valid = 1; in_tag = 8'd7;
    step();
    check("fl_one_valid", 32'(out_valid), 32'd1);
    flush = 1; in_tag = 8'd8;
    step();
    check("fl_one_kill", 32'(out_valid), 32'd0);
    flush = 0; in_valid = 0;
    step();
    check("fl_one_drop", 32'(out_valid), 32'd0);

    // Reset beats flush and handshake
    in_valid = 1; fwd_a = 32'hDEAD_BEEF; fwd_b = 32'hCAFE_F00D; in_tag = 8'd9;
    step();
    check("rs_pre_tag", 32'(out_tag), 32'd9);
    rst = 1; flush = 1;
    step();
    check("rs_valid", 32'(out_valid), 32'd0);
    check("rs_op_a", op_a, 32'd0);
    check("rs_op_b", op_b, 32'd0);
    check("rs_tag", 32'(out_tag), 32'd0);
    rst = 0; flush = 0; in_valid = 0;
    step();
    check("rs_ready", 32'(in_ready), 32'd1);
    check("rs_valid2", 32'(out_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- EX-stage operand unit for the 5-stage MIPS pipeline, generalising the single ALU-A source mux.
- Selects both ALU operands A and B per instruction, including link-address formation (A=PC, B=LINK_OFFSET) for JAL/JALR-class jumps.
- Registers the selected operands behind a valid/ready handshake with a 2-entry skid buffer, so a multi-cycle ALU/MDU can stall without losing the instruction issued into EX.
- Supports a synchronous flush for branch mispredicts and exceptions.

Parameters:
- DATA_W, 32, operand width.
- SHAMT_W, 5, shift-amount width; zero-extended to DATA_W.
- JUMP_W, 3, width of the jump-type code.
- JUMP_PC_MASK, 8'hB0, bit k set means jump code k selects A=PC and B=LINK_OFFSET (codes 4, 5, 7). Width 2**JUMP_W.
- LINK_OFFSET, 8, constant B for link-address jumps.
- TAG_W, 8, sideband (ALU op, destination register) carried alongside the operands.

Ports:
- clk, in, 1, clock.
- rst, in, 1, synchronous active-high reset.
- flush, in, 1, synchronous kill of all held entries.
- in_valid, in, 1, upstream has an instruction.
- in_ready, out, 1, stage can accept.
- fwd_a, in, DATA_W, forwarded rs data.
- fwd_b, in, DATA_W, forwarded rt data.
- shamt, in, SHAMT_W, shift amount.
- imm, in, DATA_W, extended immediate.
- pc, in, DATA_W, instruction PC.
- jump_sig, in, JUMP_W, jump-type code.
- src_a_shamt, in, 1, select shamt for A.
- src_b_imm, in, 1, select imm for B.
- in_tag, in, TAG_W, sideband.
- out_valid, out, 1, operands valid.
- out_ready, in, 1, ALU accepts.
- op_a, out, DATA_W, operand A.
- op_b, out, DATA_W, operand B.
- out_tag, out, TAG_W, sideband.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Operand selection (combinational, on inputs):
  - If JUMP_PC_MASK[jump_sig]: A=pc and B=LINK_OFFSET. This overrides src_a_shamt and src_b_imm.
  - Otherwise A = src_a_shamt ? zero_ext(shamt) : fwd_a.
  - Otherwise B = src_b_imm ? imm : fwd_b.
- Storage: a main register (drives the outputs) and a skid register, each holding {A, B, tag, valid}.
- States, encoded by the valid bits:
  - EMPTY: main=0, skid=0.
  - ONE: main=1, skid=0.
  - FULL: main=1, skid=1.
- in_ready = !skid_valid, registered-derived. It does not depend combinationally on out_ready.
- acc = in_valid & in_ready. pop = out_valid & out_ready. out_valid = main_valid.
- Transitions:
  - EMPTY, acc: load main → ONE.
  - ONE, acc & pop: load main → ONE. Full throughput of 1 per cycle.
  - ONE, acc & !pop: load skid → FULL.
  - ONE, !acc & pop → EMPTY.
  - ONE, !acc & !pop: hold.
  - FULL, pop: skid moves to main, skid cleared → ONE. No acceptance is possible in FULL because in_ready=0.
  - FULL, !pop: hold. op_a, op_b and out_tag must stay stable while out_valid & !out_ready.
- Latency: 1 cycle from acceptance in EMPTY (or ONE with pop) to out_valid.
- Ordering: strict FIFO; the skid entry is never output before the main entry.
- Flush:
  - Next cycle, main_valid=0 and skid_valid=0, so in_ready=1.
  - An input presented in the flush cycle is dropped.
  - A pop in the flush cycle still completes as seen by the ALU.
  - Data registers may keep stale values.
- rst priority: rst > flush > handshake.
- Reset values: out_valid=0, in_ready=1 (from the cycle after reset), op_a=0, op_b=0, out_tag=0, skid contents 0.
- Reset mid-operation: identical to reset from idle. Held entries are lost.
- jump_sig values not in the mask behave as non-jump.
- X on data inputs when in_valid=0 must not propagate into the valid state.

Decomposition:
- Shared package alu_pkg:
  - jump code constants J_JAL=3'b101, J_JALR=3'b100, J_BAL=3'b111.
  - Default JUMP_PC_MASK and LINK_OFFSET.
  - Width constants DATA_W and SHAMT_W.
- Sub-module pipe_skid_buf(W): generic 2-entry valid/ready skid register, reusable for the ID/EX and EX/MEM stall paths.
- This block = combinational select + pipe_skid_buf with W = 2*DATA_W+TAG_W.

Test Plan:
- Reset, then R-type ADD: fwd_a=0x11, fwd_b=0x22, jump_sig=0, both selects 0, in_valid=1, out_ready=1 → next cycle op_a=0x11, op_b=0x22, out_valid=1.
- SLL: src_a_shamt=1, shamt=5'd31, fwd_a=0xFFFF_FFFF → op_a=0x0000_001F.
- JAL: jump_sig=3'b101, pc=0x0040_0010, src_a_shamt=1, src_b_imm=1 → op_a=0x0040_0010, op_b=8. Repeat for 3'b100 and 3'b111; 3'b110 gives the normal selection.
- Backpressure: out_ready=0, issue tags 1,2,3 back-to-back → tag 1 held stable and tag 2 in skid, in_ready=0 in the cycle after tag 2 is accepted, tag 3 not accepted. Then out_ready=1 → tags emerge 1,2,3 in order with no loss or duplication.
- Flush while FULL → next cycle out_valid=0 and in_ready=1. The input present in the flush cycle never appears at the output.
- rst asserted while in ONE with flush=1 and in_valid=1 → next cycle out_valid=0, op_a=0, op_b=0, out_tag=0.
